// File: rtl/room_temp_model_if.sv
// Command/status bundle between the air-conditioning controller and the
// room thermal plant model. The controller drives the commands and the
// plant returns the room temperature and its sticky fault flag.
interface room_temp_model_if;
  logic       heating;
  logic       cooling;
  logic       load;
  logic [4:0] load_temp;
  logic [4:0] temperature;
  logic       fault;

  modport master (
    output heating, cooling, load, load_temp,
    input  temperature, fault
  );

  modport slave (
    input  heating, cooling, load, load_temp,
    output temperature, fault
  );
endinterface

// File: rtl/room_temp_model.sv
// Thermal plant model closing the loop around the air-conditioning
// controller. Heating raises the room temperature, cooling lowers it and an
// idle room drifts toward ambient, always one degree per step with each step
// paced by a run of identical command edges. Simultaneous heat and cool
// commands latch a sticky fault and freeze the temperature for that edge.
module room_temp_model #(
  parameter int unsigned INIT_TEMP    = 20,
  parameter int unsigned AMBIENT      = 15,
  parameter int unsigned HEAT_PERIOD  = 4,
  parameter int unsigned COOL_PERIOD  = 4,
  parameter int unsigned DRIFT_PERIOD = 16
) (
  input  logic               clk,
  input  logic               rst,
  room_temp_model_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_HEAT  = 2'd1,
    MODE_COOL  = 2'd2,
    MODE_CLASH = 2'd3
  } mode_t;

  localparam logic [4:0] INIT_T  = 5'(INIT_TEMP);
  localparam logic [4:0] AMB_T   = 5'(AMBIENT);
  localparam logic [4:0] MAX_T   = 5'd31;
  localparam logic [4:0] MIN_T   = 5'd0;

  mode_t      mode;
  mode_t      prev_mode;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic [7:0] run;
  logic [7:0] period;
  logic [4:0] temp_q;
  logic [4:0] temp_next;
  logic       fault_q;
  logic       fault_next;

  // Decode the controller command pair into the current plant mode.
  always_comb begin
    mode = MODE_IDLE;
    case ({bus.heating, bus.cooling})
      2'b10:   mode = MODE_HEAT;
      2'b01:   mode = MODE_COOL;
      2'b11:   mode = MODE_CLASH;
      default: mode = MODE_IDLE;
    endcase
  end

  // Select how many consecutive edges the current mode needs per step.
  always_comb begin
    period = 8'(DRIFT_PERIOD);
    case (mode)
      MODE_HEAT: period = 8'(HEAT_PERIOD);
      MODE_COOL: period = 8'(COOL_PERIOD);
      default:   period = 8'(DRIFT_PERIOD);
    endcase
  end

  // Work out the next temperature, run count and fault flag; a mode change
  // makes this edge the first of a fresh run.
  always_comb begin
    temp_next  = temp_q;
    cnt_next   = cnt;
    fault_next = fault_q;
    run        = (mode == prev_mode) ? (cnt + 8'd1) : 8'd1;

    if (bus.load) begin
      temp_next = bus.load_temp;
      cnt_next  = 8'd0;
      if (mode == MODE_CLASH) begin
        fault_next = 1'b1;
      end
    end else if (mode == MODE_CLASH) begin
      cnt_next   = 8'd0;
      fault_next = 1'b1;
    end else if (run >= period) begin
      cnt_next = 8'd0;
      case (mode)
        MODE_HEAT: begin
          if (temp_q != MAX_T) begin
            temp_next = temp_q + 5'd1;
          end
        end
        MODE_COOL: begin
          if (temp_q != MIN_T) begin
            temp_next = temp_q - 5'd1;
          end
        end
        MODE_IDLE: begin
          if (temp_q > AMB_T) begin
            temp_next = temp_q - 5'd1;
          end else if (temp_q < AMB_T) begin
            temp_next = temp_q + 5'd1;
          end
        end
        default: temp_next = temp_q;
      endcase
    end else begin
      cnt_next = run;
    end
  end

  // Plant state register; reset wins over every command including load.
  always_ff @(posedge clk) begin
    if (rst) begin
      temp_q    <= INIT_T;
      fault_q   <= 1'b0;
      cnt       <= 8'd0;
      prev_mode <= MODE_IDLE;
    end else begin
      temp_q    <= temp_next;
      fault_q   <= fault_next;
      cnt       <= cnt_next;
      prev_mode <= mode;
    end
  end

  assign bus.temperature = temp_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_room_temp_model.sv
// Directed bench for the room thermal plant model. A behavioural reference
// follows the plant rules with plain integers and is compared against the
// DUT after every clock edge; literal checks at key points pin the reference.
module tb_room_temp_model;

  logic clk;
  logic rst;

  room_temp_model_if bus ();

  room_temp_model dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors;
  int miscompares;

  int m_temp;
  int m_fault;
  int m_run;
  int m_prev;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference plant: count consecutive edges of one mode and step whenever
  // that count is a multiple of the mode's pacing period.
  always @(posedge clk) begin
    int m;
    int per;
    m = (bus.heating && bus.cooling) ? 3 : bus.heating ? 1 : bus.cooling ? 2 : 0;
    if (rst) begin
      m_temp  = 20;
      m_fault = 0;
      m_run   = 0;
      m_prev  = 0;
    end else if (bus.load) begin
      m_temp = int'(bus.load_temp);
      m_run  = 0;
      m_prev = m;
      if (m == 3) m_fault = 1;
    end else if (m == 3) begin
      m_fault = 1;
      m_run   = 0;
      m_prev  = 3;
    end else begin
      m_run  = (m == m_prev) ? m_run + 1 : 1;
      m_prev = m;
      per    = (m == 1) ? 4 : (m == 2) ? 4 : 16;
      if (m_run % per == 0) begin
        if (m == 1)      m_temp = (m_temp < 31) ? m_temp + 1 : 31;
        else if (m == 2) m_temp = (m_temp > 0) ? m_temp - 1 : 0;
        else if (m_temp > 15) m_temp = m_temp - 1;
        else if (m_temp < 15) m_temp = m_temp + 1;
      end
    end
    #1;
    vectors++;
    if (int'(bus.temperature) != m_temp || int'(bus.fault) != m_fault) begin
      miscompares++;
      $display("[TB] FAIL model_cycle t=%0t: temperature=%0d fault=%0d, expected temperature=%0d fault=%0d",
               $time, bus.temperature, bus.fault, m_temp, m_fault);
    end
  end

  task automatic applyStimulus(input logic h, input logic c, input logic ld,
                               input logic [4:0] lt, input logic r, input int n);
    bus.heating   = h;
    bus.cooling   = c;
    bus.load      = ld;
    bus.load_temp = lt;
    rst           = r;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int exp_temp, input int exp_fault);
    vectors++;
    if (int'(bus.temperature) != exp_temp || int'(bus.fault) != exp_fault) begin
      miscompares++;
      $display("[TB] FAIL %s: temperature=%0d fault=%0d, expected temperature=%0d fault=%0d",
               name, bus.temperature, bus.fault, exp_temp, exp_fault);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    int ctl;
    int cur;
    int engaged;
    int heat_temp;
    int idle_temp;

    vectors     = 0;
    miscompares = 0;
    rst           = 1'b1;
    bus.heating   = 1'b0;
    bus.cooling   = 1'b0;
    bus.load      = 1'b0;
    bus.load_temp = 5'd0;

    // Reset held for two edges, then idle drift needs a full 16 edges.
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 20, 0);
    applyStimulus(0, 0, 0, 5'd0, 0, 15);
    checkOutput("idle_before_step", 20, 0);
    applyStimulus(0, 0, 0, 5'd0, 0, 1);
    checkOutput("idle_first_step", 19, 0);

    // Heat ramp from a loaded 17.
    applyStimulus(0, 0, 1, 5'd17, 0, 1);
    checkOutput("load_17", 17, 0);
    applyStimulus(1, 0, 0, 5'd0, 0, 3);
    checkOutput("heat_no_step_yet", 17, 0);
    applyStimulus(1, 0, 0, 5'd0, 0, 1);
    checkOutput("heat_step1", 18, 0);
    applyStimulus(1, 0, 0, 5'd0, 0, 4);
    checkOutput("heat_step2", 19, 0);
    applyStimulus(1, 0, 0, 5'd0, 0, 4);
    checkOutput("heat_step3", 20, 0);

    // Saturation at both ends.
    applyStimulus(0, 0, 1, 5'd30, 0, 1);
    applyStimulus(1, 0, 0, 5'd0, 0, 12);
    checkOutput("heat_saturate_31", 31, 0);
    applyStimulus(0, 0, 1, 5'd1, 0, 1);
    applyStimulus(0, 1, 0, 5'd0, 0, 12);
    checkOutput("cool_saturate_0", 0, 0);

    // Mode change restarts the run count.
    applyStimulus(0, 0, 1, 5'd20, 0, 1);
    applyStimulus(1, 0, 0, 5'd0, 0, 3);
    applyStimulus(0, 1, 0, 5'd0, 0, 3);
    checkOutput("switch_no_step", 20, 0);
    applyStimulus(0, 1, 0, 5'd0, 0, 1);
    checkOutput("switch_first_cool", 19, 0);

    // Reset mid-run discards the partial count.
    applyStimulus(1, 0, 0, 5'd0, 0, 3);
    applyStimulus(1, 0, 0, 5'd0, 1, 1);
    checkOutput("mid_run_reset", 20, 0);
    applyStimulus(1, 0, 0, 5'd0, 0, 3);
    checkOutput("post_reset_no_step", 20, 0);
    applyStimulus(1, 0, 0, 5'd0, 0, 1);
    checkOutput("post_reset_step", 21, 0);

    // Clash latches a sticky fault and holds the temperature.
    applyStimulus(1, 1, 0, 5'd0, 0, 1);
    checkOutput("clash", 21, 1);
    applyStimulus(0, 0, 0, 5'd0, 0, 2);
    checkOutput("fault_sticky", 21, 1);
    applyStimulus(1, 0, 0, 5'd0, 0, 4);
    checkOutput("fault_heat_continues", 22, 1);
    applyStimulus(0, 0, 0, 5'd0, 1, 1);
    checkOutput("fault_cleared", 20, 0);
    applyStimulus(1, 1, 1, 5'd10, 0, 1);
    checkOutput("load_with_clash", 10, 1);
    applyStimulus(0, 0, 0, 5'd0, 1, 1);
    checkOutput("reset_after_load_clash", 20, 0);

    // Closed loop with a simple hysteretic controller starting at 25.
    applyStimulus(0, 0, 1, 5'd25, 0, 1);
    ctl = 0; engaged = 0; heat_temp = -1; idle_temp = -1;
    for (int i = 0; i < 150; i++) begin
      cur = int'(bus.temperature);
      case (ctl)
        0: if (cur >= 25) ctl = 2; else if (cur <= 18) ctl = 1;
        2: if (cur <= 21) begin ctl = 0; if (idle_temp < 0) idle_temp = cur; end
        default: if (cur >= 20) ctl = 0;
      endcase
      if (ctl == 1 && engaged == 0) begin
        engaged   = 1;
        heat_temp = cur;
      end
      applyStimulus(ctl == 1, ctl == 2, 0, 5'd0, 0, 1);
    end
    checkValue("loop_idle_temp", idle_temp, 21);
    checkValue("loop_heat_engage_temp", heat_temp, 18);
    checkValue("loop_no_fault", int'(bus.fault), 0);

    applyStimulus(0, 0, 0, 5'd0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
